// File: rtl/switch_event_pkg.sv
// ----------------------------------------------------------------------------
// switch_event_pkg
// Shared types for the switch event debouncer.
//   state_t : per-channel debounce / long-press FSM states
//   is_level: true for the states in which the switch reads as pressed
// ----------------------------------------------------------------------------
package switch_event_pkg;

    typedef enum logic [2:0] {
        UNPRESSED_S = 3'd0,
        PRESS_S     = 3'd1,
        PRESSED_S   = 3'd2,
        LONG_S      = 3'd3,
        UNPRESS_S   = 3'd4
    } state_t;

    // The lock-out after a press already counts as pressed, so the level
    // rises on the first qualifying edge rather than after the lock-out.
    function automatic logic is_level(input state_t s);
        return (s == PRESS_S) || (s == PRESSED_S) || (s == LONG_S);
    endfunction

endpackage

// File: rtl/switch_event_debouncer_if.sv
// ----------------------------------------------------------------------------
// switch_event_debouncer_if
// Bundle of one switch line and its event outputs, W channels wide.
//   raw   : switch line into the debouncer (pressed = 1 inside the design)
//   level : debounced pressed level
//   press : one-cycle press event
//   rls   : one-cycle release event
//   lng   : one-cycle long-press event
//   rpt   : one-cycle auto-repeat event
// master drives raw and observes events; slave is the debouncer side.
// ----------------------------------------------------------------------------
interface switch_event_debouncer_if #(
    parameter int W = 1
);
    logic [W-1:0] raw;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rls;
    logic [W-1:0] lng;
    logic [W-1:0] rpt;

    modport master (output raw, input  level, press, rls, lng, rpt);
    modport slave  (input  raw, output level, press, rls, lng, rpt);
endinterface

// File: rtl/switch_event_channel.sv
// ----------------------------------------------------------------------------
// switch_event_channel
// One switch channel: lock-out debounce FSM, hold counter for long press and
// optional auto-repeat. All event outputs are registered from the next state
// so they line up with the level change.
//   clk_i    : clock
//   arst_n_i : asynchronous active-low reset
//   ev       : slave side of the event bundle (raw in, events out)
// Optional feature: define SWITCH_AUTOREPEAT_EN to build the repeat counter;
// otherwise ev.rpt is constant 0.
// ----------------------------------------------------------------------------
module switch_event_channel
    import switch_event_pkg::*;
#(
    parameter int DEBOUNCE_DEPTH = 13,
    parameter int LONG_DEPTH     = 24,
    parameter int REPEAT_DEPTH   = 20
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    switch_event_debouncer_if.slave ev
);

    state_t                    state_q, state_d;
    logic [DEBOUNCE_DEPTH-1:0] deb_cnt_q, deb_cnt_d;
    logic [LONG_DEPTH-1:0]     hold_cnt_q, hold_cnt_d;
    logic                      level_q, level_d;
    logic                      press_q, press_d;
    logic                      rls_q, rls_d;
    logic                      long_q, long_d;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= UNPRESSED_S;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rls_q      <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rls_q      <= rls_d;
            long_q     <= long_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = '0;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            UNPRESSED_S: begin
                hold_cnt_d = '0;
                if (ev.raw[0]) state_d = PRESS_S;
            end
            PRESS_S: begin
                // Lock-out: raw is not looked at until the window expires.
                deb_cnt_d  = deb_cnt_q + 1'b1;
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (&deb_cnt_q) state_d = PRESSED_S;
            end
            PRESSED_S: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // Release is tested first so it wins over a coincident
                // hold terminal count.
                if (!ev.raw[0])       state_d = UNPRESS_S;
                else if (&hold_cnt_q) state_d = LONG_S;
            end
            LONG_S: begin
                if (!ev.raw[0]) state_d = UNPRESS_S;
            end
            UNPRESS_S: begin
                deb_cnt_d = deb_cnt_q + 1'b1;
                if (&deb_cnt_q) state_d = UNPRESSED_S;
            end
            default: state_d = UNPRESSED_S;
        endcase

        level_d = is_level(state_d);
        press_d = level_d & ~level_q;
        rls_d   = ~level_d & level_q;
        long_d  = (state_d == LONG_S) && (state_q != LONG_S);
    end

    assign ev.level = level_q;
    assign ev.press = press_q;
    assign ev.rls   = rls_q;
    assign ev.lng   = long_q;

`ifdef SWITCH_AUTOREPEAT_EN
    logic [REPEAT_DEPTH-1:0] rep_cnt_q, rep_cnt_d;
    logic                    rpt_q, rpt_d;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rep_cnt_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    // Counter is zero outside LONG_S, so it starts from 0 on entry.
    // A repeat coinciding with the release decision is dropped.
    always_comb begin
        rep_cnt_d = '0;
        if (state_q == LONG_S) rep_cnt_d = rep_cnt_q + 1'b1;
        rpt_d = (state_q == LONG_S) && (state_d == LONG_S) && (&rep_cnt_q);
    end

    assign ev.rpt = rpt_q;
`else
    // Never true for a legal depth: repeat is permanently off in this build.
    assign ev.rpt = (REPEAT_DEPTH < 0);
`endif

endmodule

// File: rtl/switch_event_debouncer.sv
// ----------------------------------------------------------------------------
// switch_event_debouncer
// NUM independent switch channels: 2-flop synchronizer + polarity fix here,
// FSM/counters in switch_event_channel per channel.
//   clk_i     : clock
//   arst_n_i  : asynchronous active-low reset
//   data_i    : raw asynchronous switch lines (active-low when INVERT=1)
//   level_o   : debounced pressed level
//   press_o   : one-cycle press event
//   release_o : one-cycle release event
//   long_o    : one-cycle long-press event (2^LONG_DEPTH cycles after press)
//   repeat_o  : one-cycle auto-repeat event, every 2^REPEAT_DEPTH cycles in
//               long press; only with SWITCH_AUTOREPEAT_EN defined, else 0
// ----------------------------------------------------------------------------
module switch_event_debouncer
    import switch_event_pkg::*;
#(
    parameter int NUM            = 2,
    parameter int DEBOUNCE_DEPTH = 13,
    parameter int LONG_DEPTH     = 24,
    parameter int REPEAT_DEPTH   = 20,
    parameter bit INVERT         = 1'b0
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    input  logic [NUM-1:0] data_i,
    output logic [NUM-1:0] level_o,
    output logic [NUM-1:0] press_o,
    output logic [NUM-1:0] release_o,
    output logic [NUM-1:0] long_o,
    output logic [NUM-1:0] repeat_o
);

    localparam logic [NUM-1:0] INV_MASK = {NUM{INVERT}};

    logic [NUM-1:0] sync1_q, sync1_d;
    logic [NUM-1:0] sync2_q, sync2_d;
    logic [NUM-1:0] raw;

    // Synchronizer resets to the idle line level, so a switch held through
    // reset reads as released first and then produces a clean press.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync1_q <= INV_MASK;
            sync2_q <= INV_MASK;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    always_comb begin
        sync1_d = data_i;
        sync2_d = sync1_q;
    end

    assign raw = sync2_q ^ INV_MASK;

    for (genvar g = 0; g < NUM; g++) begin : g_ch
        switch_event_debouncer_if ch_if ();

        assign ch_if.raw = raw[g];

        switch_event_channel #(
            .DEBOUNCE_DEPTH (DEBOUNCE_DEPTH),
            .LONG_DEPTH     (LONG_DEPTH),
            .REPEAT_DEPTH   (REPEAT_DEPTH)
        ) u_ch (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .ev       (ch_if)
        );

        assign level_o[g]   = ch_if.level[0];
        assign press_o[g]   = ch_if.press[0];
        assign release_o[g] = ch_if.rls[0];
        assign long_o[g]    = ch_if.lng[0];
        assign repeat_o[g]  = ch_if.rpt[0];
    end

endmodule

// File: tb/tb_switch_event_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_event_debouncer
// Directed bench: NUM=2, DEBOUNCE_DEPTH=4 (16-cycle lock-out), LONG_DEPTH=6
// (long press 64 cycles after press), REPEAT_DEPTH=3 (repeat every 8).
// Two DUTs share clock and reset: u_dut (active-high lines) and u_inv
// (INVERT=1). Inputs change 1 time unit after a rising edge; outputs are
// looked at in the same place, i.e. after that edge's register update.
// ----------------------------------------------------------------------------
module tb_switch_event_debouncer;

    localparam int NUM = 2;
    localparam int DD  = 4;
    localparam int LD  = 6;
    localparam int RD  = 3;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    switch_event_debouncer_if #(.W(NUM)) sw_if ();
    switch_event_debouncer_if #(.W(NUM)) inv_if ();

    switch_event_debouncer #(
        .NUM(NUM), .DEBOUNCE_DEPTH(DD), .LONG_DEPTH(LD), .REPEAT_DEPTH(RD), .INVERT(1'b0)
    ) u_dut (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(sw_if.raw),
        .level_o(sw_if.level), .press_o(sw_if.press), .release_o(sw_if.rls),
        .long_o(sw_if.lng), .repeat_o(sw_if.rpt)
    );

    switch_event_debouncer #(
        .NUM(NUM), .DEBOUNCE_DEPTH(DD), .LONG_DEPTH(LD), .REPEAT_DEPTH(RD), .INVERT(1'b1)
    ) u_inv (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(inv_if.raw),
        .level_o(inv_if.level), .press_o(inv_if.press), .release_o(inv_if.rls),
        .long_o(inv_if.lng), .repeat_o(inv_if.rpt)
    );

    int errors = 0;
    int checks = 0;

    // Pulse counters, updated away from the active edge.
    int n_press [NUM] = '{0, 0};
    int n_rel   [NUM] = '{0, 0};
    int n_long  [NUM] = '{0, 0};
    int n_ipress = 0;
    int n_irel   = 0;

    always @(negedge clk) begin
        for (int i = 0; i < NUM; i++) begin
            if (sw_if.press[i]) n_press[i] <= n_press[i] + 1;
            if (sw_if.rls[i])   n_rel[i]   <= n_rel[i] + 1;
            if (sw_if.lng[i])   n_long[i]  <= n_long[i] + 1;
        end
        n_ipress <= n_ipress + $countones(inv_if.press);
        n_irel   <= n_irel + $countones(inv_if.rls);
    end

`ifdef SWITCH_AUTOREPEAT_EN
    localparam logic [1:0] EXP_REP = 2'b01;
`else
    localparam logic [1:0] EXP_REP = 2'b00;
`endif

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp, sr, sl, si;
        sw_if.raw  = 2'b00;
        inv_if.raw = 2'b11;   // idle for active-low lines
        arst_n     = 1'b0;

        // ---- reset state
        step(2);
        chk("rst_out", sw_if.level | sw_if.press | sw_if.rls | sw_if.lng | sw_if.rpt, 2'b00);
        chk("rst_inv_out", inv_if.level | inv_if.press | inv_if.rls, 2'b00);
        arst_n = 1'b1;
        step(5);
        chk("idle_inv_level", inv_if.level, 2'b00);

        // ---- clean press on ch0, 30 cycles, then release
        sw_if.raw = 2'b01;
        step(2);
        chk("t1_lat2_level", sw_if.level, 2'b00);
        step(1);
        chk("t1_level", sw_if.level, 2'b01);
        chk("t1_press", sw_if.press, 2'b01);
        step(1);
        chk("t1_press_one", sw_if.press, 2'b00);
        step(26);
        chk("t1_hold_level", sw_if.level, 2'b01);
        sw_if.raw = 2'b00;
        step(2);
        chk("t1_rel_lat2", sw_if.level, 2'b01);
        step(1);
        chk("t1_rel_level", sw_if.level, 2'b00);
        chk("t1_release", sw_if.rls, 2'b01);
        step(1);
        chk("t1_release_one", sw_if.rls, 2'b00);
        chk_n("t1_npress", n_press[0], 1);
        chk_n("t1_nrel", n_rel[0], 1);
        chk_n("t1_ch1_quiet", n_press[1] + n_rel[1] + n_long[1], 0);
        step(20);

        // ---- bouncing input: toggle 12 cycles, then stable 1
        sp = n_press[0]; sr = n_rel[0];
        for (int i = 0; i < 12; i++) begin
            sw_if.raw[0] = (i % 2 == 0);
            step(1);
        end
        sw_if.raw[0] = 1'b1;
        step(30);
        chk_n("t2_one_press", n_press[0] - sp, 1);
        chk_n("t2_no_release", n_rel[0] - sr, 0);
        chk("t2_level", sw_if.level, 2'b01);
        sw_if.raw = 2'b00;
        step(23);
        chk_n("t2_final_release", n_rel[0] - sr, 1);
        chk("t2_level_low", sw_if.level, 2'b00);

        // ---- long hold: long 64 cycles after press, repeat every 8
        sl = n_long[0];
        sw_if.raw = 2'b01;
        step(3);
        chk("t3_press", sw_if.press, 2'b01);
        step(63);
        chk("t3_long_early", sw_if.lng, 2'b00);
        step(1);
        chk("t3_long", sw_if.lng, 2'b01);
        chk("t3_long_level", sw_if.level, 2'b01);
        step(1);
        chk("t3_long_one", sw_if.lng, 2'b00);
        step(6);
        chk("t3_rep_early", sw_if.rpt, 2'b00);
        step(1);
        chk("t3_rep1", sw_if.rpt, EXP_REP);
        step(1);
        chk("t3_rep1_one", sw_if.rpt, 2'b00);
        step(7);
        chk("t3_rep2", sw_if.rpt, EXP_REP);
        step(37);
        sw_if.raw = 2'b00;
        step(3);
        chk("t3_release", sw_if.rls, 2'b01);
        chk("t3_rel_level", sw_if.level, 2'b00);
        chk_n("t3_nlong", n_long[0] - sl, 1);
        step(20);

        // ---- release lands on the hold terminal cycle: release wins
        sl = n_long[0]; sr = n_rel[0];
        sw_if.raw = 2'b01;
        step(3);
        chk("t4_press", sw_if.press, 2'b01);
        step(61);
        sw_if.raw = 2'b00;
        step(2);
        chk("t4_still_level", sw_if.level, 2'b01);
        step(1);
        chk("t4_release", sw_if.rls, 2'b01);
        chk("t4_no_long", sw_if.lng, 2'b00);
        chk("t4_level_low", sw_if.level, 2'b00);
        step(1);
        chk_n("t4_nlong", n_long[0] - sl, 0);
        chk_n("t4_nrel", n_rel[0] - sr, 1);
        step(20);

        // ---- simultaneous press / release on both channels
        sw_if.raw = 2'b11;
        step(3);
        chk("t5_press_both", sw_if.press, 2'b11);
        chk("t5_level_both", sw_if.level, 2'b11);
        step(30);
        sw_if.raw = 2'b00;
        step(3);
        chk("t5_release_both", sw_if.rls, 2'b11);
        step(20);

        // ---- INVERT=1: idle produced nothing; reset mid-press
        chk_n("t6_idle_events", n_ipress + n_irel, 0);
        inv_if.raw = 2'b10;   // ch0 pressed (active low)
        step(3);
        chk("t6_press", inv_if.press, 2'b01);
        chk("t6_level", inv_if.level, 2'b01);
        step(10);
        si = n_irel;
        arst_n = 1'b0;
        #1;
        chk("t6_rst_async", inv_if.level | inv_if.press | inv_if.rls, 2'b00);
        step(1);
        chk("t6_rst_hold", inv_if.level, 2'b00);
        arst_n = 1'b1;
        step(2);
        chk("t6_after_rst_lat2", inv_if.level, 2'b00);
        step(1);
        chk("t6_held_press", inv_if.press, 2'b01);
        chk("t6_held_level", inv_if.level, 2'b01);
        step(1);
        chk_n("t6_no_release", n_irel - si, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_event_debouncer.md
SWITCH_EVENT_DEBOUNCER -- requirements
Module: switch_event_debouncer

Interface
REQ-001 SHALL have parameter NUM, default 2, number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_DEPTH, default 13, lock-out counter width; lock-out is 2^DEBOUNCE_DEPTH cycles.
REQ-003 SHALL have parameter LONG_DEPTH, default 24, hold counter width; must exceed DEBOUNCE_DEPTH.
REQ-004 SHALL have parameter REPEAT_DEPTH, default 20, auto-repeat period counter width.
REQ-005 SHALL have parameter INVERT, default 0; 1 means data_i is active-low.
REQ-006 SHALL have port clk_i  input  1  single clock for all logic.
REQ-007 SHALL have port arst_n_i  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port data_i  input  NUM  raw asynchronous switch lines.
REQ-009 SHALL have port level_o  output  NUM  debounced pressed level.
REQ-010 SHALL have port press_o  output  NUM  one-cycle press event.
REQ-011 SHALL have port release_o  output  NUM  one-cycle release event.
REQ-012 SHALL have port long_o  output  NUM  one-cycle long-press event.
REQ-013 SHALL have port repeat_o  output  NUM  one-cycle auto-repeat event.

Function
REQ-014 SHALL pass each data_i bit through a 2-flop synchronizer, then XOR with INVERT to form raw.
REQ-015 SHALL run per channel an FSM with states UNPRESSED_S, PRESS_S, PRESSED_S, LONG_S, UNPRESS_S.
REQ-016 SHALL transition UNPRESSED_S->PRESS_S when raw=1.
REQ-017 SHALL ignore raw in PRESS_S and go to PRESSED_S when deb_cnt is all ones.
REQ-018 SHALL transition PRESSED_S->UNPRESS_S on raw=0, and PRESSED_S->LONG_S when hold_cnt is all ones.
REQ-019 SHALL let release win when raw=0 and hold_cnt terminal coincide: go to UNPRESS_S, no long_o.
REQ-020 SHALL transition LONG_S->UNPRESS_S on raw=0.
REQ-021 SHALL ignore raw in UNPRESS_S and go to UNPRESSED_S when deb_cnt is all ones.
REQ-022 SHALL increment deb_cnt in PRESS_S/UNPRESS_S and clear it otherwise.
REQ-023 SHALL clear hold_cnt in UNPRESSED_S, increment it in PRESS_S/PRESSED_S, and hold it elsewhere.
REQ-024 SHALL register all outputs.
REQ-025 SHALL drive level_o=1 in PRESS_S, PRESSED_S and LONG_S; latency raw data_i edge -> level_o is 3 cycles.
REQ-026 SHALL pulse press_o for the one cycle level_o first rises, and release_o for the one cycle level_o first falls.
REQ-027 SHALL pulse long_o for the one cycle on entry to LONG_S; long-press fires 2^LONG_DEPTH cycles after press_o.
REQ-028 SHALL run channels fully independently; simultaneous events on different channels all appear the same cycle.

Reset
REQ-029 SHALL on arst_n_i=0 immediately force every FSM to UNPRESSED_S, all counters to 0, and all outputs to 0.
REQ-030 SHALL reset synchronizer flops to INVERT, so raw=0 on reset release.
REQ-031 SHALL NOT emit release_o on reset mid-press; a switch held through reset release produces press_o 3 cycles later.

Configuration
REQ-032 SHALL, with SWITCH_AUTOREPEAT_EN defined, run rep_cnt (REPEAT_DEPTH bits) in LONG_S, cleared on LONG_S entry.
REQ-033 SHALL, with SWITCH_AUTOREPEAT_EN defined, pulse repeat_o each time rep_cnt is all ones, i.e. every 2^REPEAT_DEPTH cycles.
REQ-034 SHALL, without SWITCH_AUTOREPEAT_EN, omit rep_cnt and tie repeat_o to 0; the port list is unchanged.

Structure
REQ-035 SHALL place state_t (the five FSM states) in package switch_event_pkg.
REQ-036 SHALL implement per-channel FSM and counters in sub-module switch_event_channel, generated NUM times; the synchronizer stays in the top.

Verification (NUM=2, DEBOUNCE_DEPTH=4, LONG_DEPTH=6, REPEAT_DEPTH=3)
REQ-037 SHALL test a clean 0->1 on data_i[0] held 30 cycles -> level_o[0] high 3 cycles later, one press_o; on release one release_o; channel 1 stays silent.
REQ-038 SHALL test data_i[0] toggling every cycle for 12 cycles then stable 1 -> exactly one press_o and no release_o.
REQ-039 SHALL test data_i[0] held 120 cycles -> long_o 64 cycles after press_o; with the macro, repeat_o every 8 cycles thereafter; without it, repeat_o stays 0.
REQ-040 SHALL test release timed so raw falls on the hold_cnt terminal cycle -> release_o pulses and long_o stays 0.
REQ-041 SHALL test INVERT=1 with data_i=2'b11 idle -> no events, then arst_n_i pulsed low mid-press -> outputs 0 within the reset cycle and no release_o.
REQ-042 SHALL test simultaneous presses on both channels -> press_o=2'b11 in the same cycle.
